// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and write-port count for the register file.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF = 32;
  localparam int NWR = 2;
endpackage

// File: rtl/regfile_sb_score.sv
// regfile_sb_score: busy scoreboard with sticky overlap flag; a new producer beats a same-cycle clear.
module regfile_sb_score import regfile_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [DEPTH-1:0]  clr,
  output logic [DEPTH-1:0]  busy,
  output logic              sb_ovf
);
  logic [DEPTH-1:0] w_set;
  for (genvar a = 0; a < DEPTH; a++) begin : g_set
    assign w_set[a] = set_en && set_addr == ADDR_W'(a);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy   <= '0;
      sb_ovf <= 1'b0;
    end else begin
      busy   <= w_set | (busy & ~clr);
      sb_ovf <= sb_ovf | (|(w_set & busy & ~clr));
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2-write/NRD-read register file with busy scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle write data to reads.
module regfile_sb import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NRD = 2,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NWR-1:0]               wr_en,
  input  logic [NWR-1:0][ADDR_W-1:0]   wr_addr,
  input  logic [NWR-1:0][DATA_W-1:0]   wr_data,
  input  logic [NRD-1:0]               rd_en,
  input  logic [NRD-1:0][ADDR_W-1:0]   rd_addr,
  output logic [NRD-1:0][DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]               rd_ready,
  input  logic                         sb_set_en,
  input  logic [ADDR_W-1:0]            sb_set_addr,
  output logic [DEPTH-1:0]             busy,
  output logic                         sb_ovf
);
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);
  logic              r_live;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [NWR-1:0]    w_wv;
  logic [DEPTH-1:0]  w_clr;
  logic              w_set;
  // r_live stays low through the edge at which reset deasserts, discarding that edge's writes/sets
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_live <= 1'b0;
    else r_live <= 1'b1;
  end
  for (genvar i = 0; i < NWR; i++) begin : g_wv
    assign w_wv[i] = r_live && wr_en[i] && wr_addr[i] != '0 && {1'b0, wr_addr[i]} < LIM;
  end
  assign w_set = r_live && sb_set_en && sb_set_addr != '0 && {1'b0, sb_set_addr} < LIM;
  for (genvar a = 0; a < DEPTH; a++) begin : g_reg
    logic [NWR-1:0] w_hit;
    for (genvar i = 0; i < NWR; i++) begin : g_hit
      assign w_hit[i] = w_wv[i] && wr_addr[i] == ADDR_W'(a);
    end
    assign w_clr[a] = |w_hit;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_mem[a] <= '0;
      else if (|w_hit) r_mem[a] <= w_hit[1] ? wr_data[1] : wr_data[0];
    end
  end
  regfile_sb_score #(.DEPTH(DEPTH)) u_score (
    .clk      (clk),
    .rst      (rst),
    .set_en   (w_set),
    .set_addr (sb_set_addr),
    .clr      (w_clr),
    .busy     (busy),
    .sb_ovf   (sb_ovf)
  );
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic              w_ok;
    logic              w_busy;
    logic [DATA_W-1:0] w_val;
    assign w_ok   = rd_addr[k] != '0 && {1'b0, rd_addr[k]} < LIM;
    assign w_busy = w_ok && busy[rd_addr[k]];
`ifdef REGFILE_SB_BYPASS_EN
    logic [NWR-1:0] w_bh;
    for (genvar i = 0; i < NWR; i++) begin : g_bh
      assign w_bh[i] = w_wv[i] && wr_addr[i] == rd_addr[k];
    end
    assign w_val       = w_bh[1] ? wr_data[1] : w_bh[0] ? wr_data[0] : r_mem[rd_addr[k]];
    assign rd_ready[k] = rd_en[k] && (!w_busy || |w_bh);
`else
    assign w_val       = r_mem[rd_addr[k]];
    assign rd_ready[k] = rd_en[k] && !w_busy;
`endif
    assign rd_data[k] = (rd_en[k] && w_ok) ? w_val : '0;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard-driven bench for regfile_sb; honours REGFILE_SB_BYPASS_EN.
module tb_regfile_sb;
  localparam int DW = 32, D = 32, AW = 5;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] wr_en = '0;
  logic [1:0][AW-1:0] wr_addr = '0;
  logic [1:0][DW-1:0] wr_data = '0;
  logic [1:0] rd_en = '0;
  logic [1:0][AW-1:0] rd_addr = '0;
  logic [1:0][DW-1:0] rd_data;
  logic [1:0] rd_ready;
  logic sb_set_en = 1'b0;
  logic [AW-1:0] sb_set_addr = '0;
  logic [D-1:0] busy;
  logic sb_ovf;
  always #5 clk = ~clk;
  regfile_sb dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy(busy), .sb_ovf(sb_ovf)
  );
  typedef struct {string tag; int kind; logic [63:0] exp;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] m [D];
  logic [D-1:0] bm;
  logic om;
  bit live;
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_chk++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  function automatic logic [63:0] obs(input int kind);
    case (kind)
      0: return 64'(rd_data[0]);
      1: return 64'(rd_data[1]);
      2: return 64'(rd_ready);
      3: return 64'(busy);
      default: return 64'(sb_ovf);
    endcase
  endfunction
  task automatic push(input string tag, input int kind, input logic [63:0] e);
    q.push_back('{tag, kind, e});
  endtask
  task automatic drain();
    exp_t e;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, obs(e.kind), e.exp);
    end
  endtask
  function automatic bit byp(input int k);
`ifdef REGFILE_SB_BYPASS_EN
    return live && rst && ((wr_en[0] && wr_addr[0] == rd_addr[k]) || (wr_en[1] && wr_addr[1] == rd_addr[k]));
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [DW-1:0] exp_rd(input int k);
    logic [DW-1:0] v;
    if (!rd_en[k] || rd_addr[k] == 0) return '0;
    v = m[rd_addr[k]];
    if (byp(k)) v = (wr_en[1] && wr_addr[1] == rd_addr[k]) ? wr_data[1] : wr_data[0];
    return v;
  endfunction
  function automatic logic exp_rdy(input int k);
    return rd_en[k] && (rd_addr[k] == 0 || !bm[rd_addr[k]] || byp(k));
  endfunction
  task automatic push_model(input string tag);
    push({tag, "_rd0"}, 0, 64'(exp_rd(0)));
    push({tag, "_rd1"}, 1, 64'(exp_rd(1)));
    push({tag, "_rdy"}, 2, 64'({exp_rdy(1), exp_rdy(0)}));
    push({tag, "_busy"}, 3, 64'(bm));
    push({tag, "_ovf"}, 4, 64'(om));
  endtask
  task automatic clear_model();
    for (int a = 0; a < D; a++) m[a] = '0;
    bm = '0;
    om = 1'b0;
    live = 1'b0;
  endtask
  task automatic tick();
    logic [D-1:0] clr;
    clr = '0;
    if (rst && live) begin
      for (int i = 0; i < 2; i++)
        if (wr_en[i] && wr_addr[i] != 0) begin
          m[wr_addr[i]] = wr_data[i];
          clr[wr_addr[i]] = 1'b1;
        end
      if (sb_set_en && sb_set_addr != 0 && bm[sb_set_addr] && !clr[sb_set_addr]) om = 1'b1;
      bm = bm & ~clr;
      if (sb_set_en && sb_set_addr != 0) bm[sb_set_addr] = 1'b1;
    end
    @(posedge clk);
    live = rst;
    #1;
  endtask
  task automatic idle();
    wr_en = '0;
    sb_set_en = 1'b0;
    rd_en = '0;
  endtask
  initial begin
    clear_model();
    #1 rst = 1'b0;
    wr_en = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {32'h1, 32'h2};
    sb_set_en = 1'b1; sb_set_addr = 5'd4;
    tick(); tick();
    #2 rst = 1'b1;
    wr_addr = {5'd10, 5'd10}; sb_set_addr = 5'd10;
    tick();
    idle();
    for (int a = 0; a < D; a += 2) begin
      rd_en = 2'b11; rd_addr = {AW'(a + 1), AW'(a)};
      push("rst_rd0", 0, 0);
      push("rst_rd1", 1, 0);
      push("rst_rdy", 2, 2'b11);
      drain();
    end
    push("rst_busy", 3, 0);
    push("rst_ovf", 4, 0);
    drain();
    rd_en = 2'b00; rd_addr = {5'd9, 5'd9};
    push("rd_dis", 0, 0);
    push("rd_dis_rdy", 2, 0);
    drain();
    wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_data = {32'h5555_1111, 32'hAAAA_0000};
    tick();
    idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    push("waw_port1", 0, 32'h5555_1111);
    push_model("waw");
    drain();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hDEAD_BEEF};
    tick();
    idle(); rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
    push("r0_data", 0, 0);
    push("r0_rdy", 2, 2'b11);
    drain();
    wr_en = 2'b11; wr_addr = {5'd8, 5'd6}; wr_data = {32'h8888, 32'h6666};
    tick();
    idle(); rd_en = 2'b11; rd_addr = {5'd8, 5'd6};
    push("split_p0", 0, 32'h6666);
    push("split_p1", 1, 32'h8888);
    drain();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'h1111};
    tick();
    idle(); wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'h1234};
    rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
`ifdef REGFILE_SB_BYPASS_EN
    push("byp_data", 0, 32'h1234);
`else
    push("nobyp_data", 0, 32'h1111);
`endif
    push("byp_rdy", 2, 2'b01);
    drain();
    tick();
    idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    push("after_wr", 0, 32'h1234);
    drain();
    sb_set_en = 1'b1; sb_set_addr = 5'd3;
    tick();
    idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
    push("busy3_rdy", 2, 2'b00);
    push("busy3_vec", 3, 32'h8);
    drain();
`ifdef REGFILE_SB_BYPASS_EN
    wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {32'h77, 32'h0};
    push("byp_busy_rdy", 2, 2'b01);
    push("byp_busy_data", 0, 32'h77);
    drain();
`endif
    idle(); sb_set_en = 1'b1; sb_set_addr = 5'd3;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h33};
    tick();
    idle();
    push("setclr_busy", 3, 32'h8);
    push("setclr_ovf", 4, 0);
    drain();
    sb_set_en = 1'b1; sb_set_addr = 5'd3;
    tick();
    idle();
    push("reset_ovf", 4, 1);
    push("reset_busy", 3, 32'h8);
    drain();
    wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {32'h99, 32'h0};
    tick();
    idle();
    push("clr_busy", 3, 0);
    push("ovf_sticky", 4, 1);
    drain();
    sb_set_en = 1'b1; sb_set_addr = 5'd0;
    tick();
    idle();
    push("busy0_never", 3, 0);
    drain();
    for (int n = 0; n < 60; n++) begin
      wr_en = 2'($urandom);
      wr_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      wr_data = {$urandom, $urandom};
      sb_set_en = 1'($urandom);
      sb_set_addr = AW'($urandom_range(0, 7));
      rd_en = 2'($urandom);
      rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      push_model("rnd");
      drain();
      tick();
    end
    idle();
    rd_en = 2'b11; rd_addr = {5'd7, 5'd5};
    #2 rst = 1'b0;
    clear_model();
    push("async_rd0", 0, 0);
    push("async_rd1", 1, 0);
    push("async_busy", 3, 0);
    push("async_ovf", 4, 0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter DEPTH, default 32, register count; ADDR_W = clog2(DEPTH) is derived locally and is not overridable.
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  2  per-write-port enable.
REQ-007 wr_addr  input  2 x ADDR_W  write addresses.
REQ-008 wr_data  input  2 x DATA_W  write data.
REQ-009 rd_en  input  NRD  per-read-port enable.
REQ-010 rd_addr  input  NRD x ADDR_W  read addresses.
REQ-011 rd_data  output  NRD x DATA_W  read data.
REQ-012 rd_ready  output  NRD  read value is final (no pending producer).
REQ-013 sb_set_en  input  1  mark a register busy (producer issued).
REQ-014 sb_set_addr  input  ADDR_W  register to mark busy.
REQ-015 busy  output  DEPTH  scoreboard vector.
REQ-016 sb_ovf  output  1  sticky WAW-overlap flag.

Function
REQ-017 Each write port i writes wr_data[i] to wr_addr[i] on the clock edge when wr_en[i]=1 and wr_addr[i]!=0.
REQ-018 Register 0 reads as 0 always; writes to it are discarded; busy[0] is never set.
REQ-019 When both write ports hit the same address in one cycle, port 1 data is stored.
REQ-020 Reads are combinational; rd_data[k] is 0 when rd_en[k]=0; addresses >= DEPTH read 0 and are ignored for write and set.
REQ-021 Registers with no write hold their value; no other state changes on an idle cycle.
REQ-022 Scoreboard: busy[a] sets on the edge with sb_set_en=1 and sb_set_addr=a; it clears on the edge with an enabled write to a.
REQ-023 Set and clear of the same address in one cycle leaves busy[a]=1 (new producer wins).
REQ-024 sb_set_en to an address already busy and not cleared that cycle sets sb_ovf=1; sb_ovf stays 1 until reset; the register stays busy.
REQ-025 rd_ready[k] = rd_en[k] and (busy[rd_addr[k]]=0 or a same-cycle enabled write targets rd_addr[k], the latter only when bypass is compiled in); rd_ready[k]=1 for address 0.

Reset
REQ-026 rst=0 asynchronously clears all registers, busy, and sb_ovf to 0; rd_data follows from the cleared storage.
REQ-027 Writes and sets presented during reset, or on the edge at which reset deasserts, are discarded.

Configuration
REQ-028 Macro REGFILE_SB_BYPASS_EN defined: a read whose address matches an enabled same-cycle write returns that write data (port 1 over port 0) and reports ready; address 0 is still 0.
REQ-029 REGFILE_SB_BYPASS_EN undefined: reads return stored contents only; written data is visible one cycle after the write edge.

Structure
REQ-030 Package regfile_pkg holds the DATA_W/DEPTH defaults and the write-port-count constant (2).
REQ-031 Sub-module regfile_sb_score holds the busy vector, sb_ovf, and set/clear priority; storage and read muxing remain in regfile_sb.

Verification
REQ-032 Reset, then read all addresses -> every rd_data=0, busy=0, sb_ovf=0.
REQ-033 Both ports write address 5 (port0 0xAAAA_0000, port1 0x5555_1111); next cycle read 5 -> 0x5555_1111.
REQ-034 Write 0xDEAD_BEEF to address 0 -> read 0 returns 0.
REQ-035 With bypass: write 0x1234 to address 7 and read 7 in the same cycle -> rd_data=0x1234, rd_ready=1. Without bypass: old value returned, 0x1234 appears next cycle.
REQ-036 Set busy[3]; read 3 -> rd_ready=0. Set 3 and write 3 in one cycle -> busy[3]=1. Set 3 again -> sb_ovf=1. A lone write to 3 -> busy[3]=0 and sb_ovf still 1.
REQ-037 Assert rst mid-operation with registers written -> all state 0 immediately, without a clock edge.
